// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: segment bit order,
// the all-off pattern and the active-low hex font.
package seg_pkg;
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;
    localparam int SEG_W = SEG_G - SEG_A + 1;

    localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

    // Entry n is the glyph for hex digit n; listed F down to 0.
    localparam logic [15:0][SEG_W-1:0] SEG_FONT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
endpackage

// File: rtl/seg_hex_font.sv
// Combinational hex nibble to active-low seven-segment decoder.
module seg_hex_font
    import seg_pkg::*;
(
    input  logic [3:0]       i_hex,
    output logic [SEG_W-1:0] o_seg
);
    assign o_seg = SEG_FONT[i_hex];
endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed N-digit common-anode scanner with double-buffered data,
// decimal points, blanking, leading-zero suppression and PWM dimming.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int DIV        = 100000,
    parameter int PWM_BITS   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_en,
    input  logic [PWM_BITS-1:0]     bright,
    output logic [NUM_DIGITS-1:0]   sm_wei,
    output logic [6:0]              sm_duan,
    output logic                    sm_dp,
    output logic                    frame_done
);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PCNT_W = $clog2(DIV);

    logic [PCNT_W-1:0]       r_pcnt;
    logic [IDX_W-1:0]        r_idx;
    logic [PWM_BITS-1:0]     r_pwm;
    logic [4*NUM_DIGITS-1:0] r_sh_data, r_act_data;
    logic [NUM_DIGITS-1:0]   r_sh_dp, r_act_dp;
    logic [NUM_DIGITS-1:0]   r_sh_blank, r_act_blank;
    logic [NUM_DIGITS-1:0]   r_wei;
    logic [6:0]              r_duan;
    logic                    r_dp;
    logic                    r_frame_done;

    logic                    w_tick, w_frame, w_on;
    logic [3:0]              w_nib;
    logic                    w_sel_dp, w_sel_blank, w_sel_supp;
    logic [NUM_DIGITS-1:0]   w_supp;
    logic                    w_zero_run;
    logic [SEG_W-1:0]        w_font;

    assign w_tick  = (r_pcnt == PCNT_W'(DIV - 1));
    assign w_frame = w_tick && (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_on    = (&bright) || (r_pwm < bright);

    // A digit is suppressed when it and every more-significant nibble are zero.
    always_comb begin
        w_zero_run = 1'b1;
        w_supp     = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            w_zero_run = w_zero_run & (r_act_data[4*i +: 4] == 4'h0);
            w_supp[i]  = lz_en & w_zero_run;
        end
    end

    always_comb begin
        w_nib       = '0;
        w_sel_dp    = 1'b0;
        w_sel_blank = 1'b0;
        w_sel_supp  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib       = r_act_data[4*i +: 4];
                w_sel_dp    = r_act_dp[i];
                w_sel_blank = r_act_blank[i];
                w_sel_supp  = w_supp[i];
            end
        end
    end

    seg_hex_font u_font (
        .i_hex (w_nib),
        .o_seg (w_font)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt <= '0;
            r_idx  <= '0;
            r_pwm  <= '0;
        end else begin
            r_pwm  <= r_pwm + 1'b1;
            r_pcnt <= w_tick ? '0 : r_pcnt + 1'b1;
            if (w_tick)
                r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end
    end

    // Shadow takes loads any time; active only swaps at the frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_data    <= '0;
            r_sh_dp      <= '0;
            r_sh_blank   <= '0;
            r_act_data   <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            if (load) begin
                r_sh_data  <= data;
                r_sh_dp    <= dp;
                r_sh_blank <= blank_mask;
            end
            if (w_frame) begin
                r_act_data  <= r_sh_data;
                r_act_dp    <= r_sh_dp;
                r_act_blank <= r_sh_blank;
            end
            r_frame_done <= w_frame;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wei  <= '1;
            r_duan <= SEG_OFF;
            r_dp   <= 1'b1;
        end else if (w_on && !w_sel_blank) begin
            r_wei  <= ~(NUM_DIGITS'(1) << r_idx);
            r_duan <= w_sel_supp ? SEG_OFF : w_font;
            r_dp   <= ~w_sel_dp;
        end else begin
            r_wei  <= '1;
            r_duan <= SEG_OFF;
            r_dp   <= 1'b1;
        end
    end

    assign sm_wei     = r_wei;
    assign sm_duan    = r_duan;
    assign sm_dp      = r_dp;
    assign frame_done = r_frame_done;
endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display at NUM_DIGITS=4, DIV=4, PWM_BITS=2.
module tb_seg_scan_display;
    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank_mask;
    logic        lz_en;
    logic [1:0]  bright;
    logic [3:0]  sm_wei;
    logic [6:0]  sm_duan;
    logic        sm_dp;
    logic        frame_done;

    int n_chk = 0;
    int n_err = 0;
    int k     = 0;   // rising edges since the last reset release

    seg_scan_display #(.NUM_DIGITS(4), .DIV(4), .PWM_BITS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data       (data),
        .dp         (dp),
        .blank_mask (blank_mask),
        .lz_en      (lz_en),
        .bright     (bright),
        .sm_wei     (sm_wei),
        .sm_duan    (sm_duan),
        .sm_dp      (sm_dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic go_to(input int t);
        while (k < t) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] wei, input logic [6:0] duan, input logic dpo);
        n_chk++;
        assert (sm_wei === wei && sm_duan === duan && sm_dp === dpo) else begin
            n_err++;
            $error("FAIL %s @k=%0d: got wei=%b duan=%h dp=%b, want wei=%b duan=%h dp=%b",
                   tag, k, sm_wei, sm_duan, sm_dp, wei, duan, dpo);
        end
    endtask

    task automatic chk_fd(input string tag, input logic fd);
        n_chk++;
        assert (frame_done === fd) else begin
            n_err++;
            $error("FAIL %s @k=%0d: got frame_done=%b, want %b", tag, k, frame_done, fd);
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; data = '0; dp = '0; blank_mask = '0;
        lz_en = 1'b0; bright = 2'd3;
        repeat (3) @(negedge clk);
        chk("reset", 4'b1111, 7'h7F, 1'b1);
        chk_fd("reset_fd", 1'b0);

        rst = 1'b0; k = 0; load = 1'b1; data = 16'h1234;
        go_to(1);  load = 1'b0;
        chk("first_d0_old", 4'b1110, 7'h40, 1'b1);
        go_to(15); chk_fd("fd_before", 1'b0);
        go_to(16); chk_fd("fd_boundary", 1'b0 | 1'b1);
        go_to(17); chk("h1234_d0", 4'b1110, 7'h19, 1'b1); chk_fd("fd_one_cycle", 1'b0);
        go_to(21); chk("h1234_d1", 4'b1101, 7'h30, 1'b1);
        go_to(25); chk("h1234_d2", 4'b1011, 7'h24, 1'b1);
        go_to(29); chk("h1234_d3", 4'b0111, 7'h79, 1'b1);
        go_to(32); chk_fd("fd_period", 1'b1);

        go_to(33); data = 16'h00A0; lz_en = 1'b1; load = 1'b1;
        go_to(34); load = 1'b0;
        go_to(49); chk("lz_d0", 4'b1110, 7'h40, 1'b1);
        go_to(53); chk("lz_d1", 4'b1101, 7'h08, 1'b1);
        go_to(57); chk("lz_d2", 4'b1011, 7'h7F, 1'b1);
        go_to(61); chk("lz_d3", 4'b0111, 7'h7F, 1'b1);

        bright = 2'd1;
        go_to(65); chk("pwm1_on",   4'b1110, 7'h40, 1'b1);
        go_to(66); chk("pwm1_off1", 4'b1111, 7'h7F, 1'b1);
        go_to(67); chk("pwm1_off2", 4'b1111, 7'h7F, 1'b1);
        go_to(68); chk("pwm1_off3", 4'b1111, 7'h7F, 1'b1);
        bright = 2'd0;
        go_to(69); chk("pwm0_a", 4'b1111, 7'h7F, 1'b1);
        go_to(70); chk("pwm0_b", 4'b1111, 7'h7F, 1'b1);
        bright = 2'd3;

        go_to(79); data = 16'hFFFF; load = 1'b1;
        go_to(80); load = 1'b0; chk_fd("fd_bnd_load", 1'b1);
        go_to(81);  chk("bnd_old_d0", 4'b1110, 7'h40, 1'b1);
        go_to(85);  chk("bnd_old_d1", 4'b1101, 7'h08, 1'b1);
        go_to(97);  chk("bnd_new_d0", 4'b1110, 7'h0E, 1'b1);
        go_to(101); chk("bnd_new_d1", 4'b1101, 7'h0E, 1'b1);
        go_to(105); chk("bnd_new_d2", 4'b1011, 7'h0E, 1'b1);
        go_to(109); chk("bnd_new_d3", 4'b0111, 7'h0E, 1'b1);

        go_to(113); data = 16'h1111; dp = 4'b1111; load = 1'b1;
        go_to(114); data = 16'h89AB; dp = 4'b0001; blank_mask = 4'b0100;
        go_to(115); load = 1'b0;
        go_to(129); chk("mask_d0_dp", 4'b1110, 7'h03, 1'b0);
        go_to(133); chk("mask_d1",    4'b1101, 7'h08, 1'b1);
        go_to(137); chk("mask_d2",    4'b1111, 7'h7F, 1'b1);
        go_to(141); chk("mask_d3",    4'b0111, 7'h00, 1'b1);

        data = 16'h7777; dp = '0; blank_mask = '0; load = 1'b1;
        go_to(142); load = 1'b0; rst = 1'b1;
        go_to(143); chk("midrst", 4'b1111, 7'h7F, 1'b1); chk_fd("midrst_fd", 1'b0);
        rst = 1'b0; k = 0;
        go_to(1);  chk("post_rst_d0", 4'b1110, 7'h40, 1'b1);
        go_to(17); chk("post_rst_shadow", 4'b1110, 7'h40, 1'b1);
        go_to(21); chk("post_rst_lz_d1", 4'b1101, 7'h7F, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
